// File: rtl/change_dispense_ctrl_pkg.sv
// Coin codes, coin values and controller state encodings for the change dispenser.
// The coin codes match the encoding used by vending_machine.
package change_dispense_ctrl_pkg;

    typedef logic [2:0] coin_t;

    localparam coin_t COIN_NONE    = 3'b000;
    localparam coin_t COIN_NICKEL  = 3'b001;
    localparam coin_t COIN_DIME    = 3'b010;
    localparam coin_t COIN_QUARTER = 3'b011;
    localparam coin_t COIN_HALF    = 3'b100;
    localparam coin_t COIN_DOLLAR  = 3'b101;

    // Coin values expressed in nickels
    localparam logic [4:0] VAL_NICKEL  = 5'd1;
    localparam logic [4:0] VAL_DIME    = 5'd2;
    localparam logic [4:0] VAL_QUARTER = 5'd5;
    localparam logic [4:0] VAL_HALF    = 5'd10;
    localparam logic [4:0] VAL_DOLLAR  = 5'd20;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_EJECT  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    typedef struct packed {
        logic  found;
        coin_t code;
    } pick_t;

    function automatic logic [4:0] coin_value(input coin_t code);
        case (code)
            COIN_NICKEL:  return VAL_NICKEL;
            COIN_DIME:    return VAL_DIME;
            COIN_QUARTER: return VAL_QUARTER;
            COIN_HALF:    return VAL_HALF;
            COIN_DOLLAR:  return VAL_DOLLAR;
            default:      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Payout request, ejector handshake and status bundle of the change dispenser.
interface change_dispense_ctrl_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 5
) ();
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [4:0]       avail;
    logic             eject_ack;
    logic             eject_req;
    logic [2:0]       eject_coin;
    logic             busy;
    logic             done;
    logic             fail;
    logic             jam;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] nickel_out;
    logic [CNT_W-1:0] dime_out;
    logic [CNT_W-1:0] quarter_out;
    logic [CNT_W-1:0] half_dollar_out;
    logic [CNT_W-1:0] dollar_out;

    modport master (
        output start, amount, avail, eject_ack,
        input  eject_req, eject_coin, busy, done, fail, jam, remaining,
        input  nickel_out, dime_out, quarter_out, half_dollar_out, dollar_out
    );

    modport slave (
        input  start, amount, avail, eject_ack,
        output eject_req, eject_coin, busy, done, fail, jam, remaining,
        output nickel_out, dime_out, quarter_out, half_dollar_out, dollar_out
    );
endinterface

// File: rtl/change_dispense_ctrl_coin_pick.sv
// Greedy coin selector: largest available denomination not exceeding what is still owed.
module change_dispense_ctrl_coin_pick
    import change_dispense_ctrl_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [4:0]       avail,
    output pick_t            pick
);

    logic [4:0] fits_s;

    assign fits_s[0] = avail[0] && (AMT_W'(VAL_NICKEL)  <= remaining);
    assign fits_s[1] = avail[1] && (AMT_W'(VAL_DIME)    <= remaining);
    assign fits_s[2] = avail[2] && (AMT_W'(VAL_QUARTER) <= remaining);
    assign fits_s[3] = avail[3] && (AMT_W'(VAL_HALF)    <= remaining);
    assign fits_s[4] = avail[4] && (AMT_W'(VAL_DOLLAR)  <= remaining);

    // Priority encode dollar > half > quarter > dime > nickel
    always_comb begin
        pick.found = 1'b0;
        pick.code  = COIN_NONE;
        if (fits_s[4]) begin
            pick.found = 1'b1;
            pick.code  = COIN_DOLLAR;
        end else if (fits_s[3]) begin
            pick.found = 1'b1;
            pick.code  = COIN_HALF;
        end else if (fits_s[2]) begin
            pick.found = 1'b1;
            pick.code  = COIN_QUARTER;
        end else if (fits_s[1]) begin
            pick.found = 1'b1;
            pick.code  = COIN_DIME;
        end else if (fits_s[0]) begin
            pick.found = 1'b1;
            pick.code  = COIN_NICKEL;
        end else begin
            pick.found = 1'b0;
            pick.code  = COIN_NONE;
        end
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change/refund payout sequencer: picks coins greedily and drives the ejector req/ack handshake.
module change_dispense_ctrl
    import change_dispense_ctrl_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst,
    change_dispense_ctrl_if.slave bus
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]       state_r;
    logic [AMT_W-1:0] remaining_r;
    logic             req_r;
    coin_t            coin_r;
    logic             busy_r;
    logic             done_r;
    logic             fail_r;
    logic             jam_r;
    logic [TMO_W-1:0] tmo_r;
    logic [CNT_W-1:0] nickel_r;
    logic [CNT_W-1:0] dime_r;
    logic [CNT_W-1:0] quarter_r;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] dollar_r;
    pick_t            pick_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + CNT_W'(1);
        end
    endfunction

    change_dispense_ctrl_coin_pick #(.AMT_W(AMT_W)) u_coin_pick (
        .remaining (remaining_r),
        .avail     (bus.avail),
        .pick      (pick_s)
    );

    // Payout FSM with all status outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= {AMT_W{1'b0}};
            req_r       <= 1'b0;
            coin_r      <= COIN_NONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            jam_r       <= 1'b0;
            tmo_r       <= {TMO_W{1'b0}};
            nickel_r    <= {CNT_W{1'b0}};
            dime_r      <= {CNT_W{1'b0}};
            quarter_r   <= {CNT_W{1'b0}};
            half_r      <= {CNT_W{1'b0}};
            dollar_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        remaining_r <= bus.amount;
                        nickel_r    <= {CNT_W{1'b0}};
                        dime_r      <= {CNT_W{1'b0}};
                        quarter_r   <= {CNT_W{1'b0}};
                        half_r      <= {CNT_W{1'b0}};
                        dollar_r    <= {CNT_W{1'b0}};
                        jam_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining_r == {AMT_W{1'b0}}) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (pick_s.found) begin
                        coin_r  <= pick_s.code;
                        req_r   <= 1'b1;
                        tmo_r   <= {TMO_W{1'b0}};
                        state_r <= ST_EJECT;
                    end else begin
                        fail_r  <= 1'b1;
                        state_r <= ST_FAIL;
                    end
                end
                ST_EJECT: begin
                    // An ack arriving on the timeout cycle still counts as a dropped coin
                    if (bus.eject_ack) begin
                        remaining_r <= remaining_r - AMT_W'(coin_value(coin_r));
                        case (coin_r)
                            COIN_NICKEL:  nickel_r  <= sat_inc(nickel_r);
                            COIN_DIME:    dime_r    <= sat_inc(dime_r);
                            COIN_QUARTER: quarter_r <= sat_inc(quarter_r);
                            COIN_HALF:    half_r    <= sat_inc(half_r);
                            COIN_DOLLAR:  dollar_r  <= sat_inc(dollar_r);
                            default:      nickel_r  <= nickel_r;
                        endcase
                        req_r   <= 1'b0;
                        coin_r  <= COIN_NONE;
                        state_r <= ST_SELECT;
                    end else if (tmo_r == TMO_W'(ACK_TIMEOUT - 1)) begin
                        jam_r   <= 1'b1;
                        req_r   <= 1'b0;
                        coin_r  <= COIN_NONE;
                        fail_r  <= 1'b1;
                        state_r <= ST_FAIL;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_FAIL: begin
                    fail_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    coin_r  <= COIN_NONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    fail_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.eject_req       = req_r;
    assign bus.eject_coin      = coin_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.fail            = fail_r;
    assign bus.jam             = jam_r;
    assign bus.remaining       = remaining_r;
    assign bus.nickel_out      = nickel_r;
    assign bus.dime_out        = dime_r;
    assign bus.quarter_out     = quarter_r;
    assign bus.half_dollar_out = half_r;
    assign bus.dollar_out      = dollar_r;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: emulated ejector plus a greedy-payout reference model.
module tb_change_dispense_ctrl;

    localparam int AMT_W       = 8;
    localparam int CNT_W       = 5;
    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispense_ctrl_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

    change_dispense_ctrl #(.AMT_W(AMT_W), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int coin_val[5] = '{1, 2, 5, 10, 20};
    int exp_seq[$];
    int exp_cnt[5];
    int exp_rem;
    bit exp_fail;

    int seen_q[$];
    bit got_done;
    bit got_fail;
    int req_cycles;

    // Greedy payout computed from the coin values directly; index i is coin code i+1
    function automatic void model(input int amt, input logic [4:0] av);
        int rem;
        bit picked;
        exp_seq.delete();
        for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
        rem = amt;
        exp_fail = 1'b0;
        while (rem > 0 && !exp_fail) begin
            picked = 1'b0;
            for (int i = 4; i >= 0; i--) begin
                if (!picked && av[i] && coin_val[i] <= rem) begin
                    picked = 1'b1;
                    exp_seq.push_back(i + 1);
                    rem -= coin_val[i];
                    if (exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
                end
            end
            if (!picked) exp_fail = 1'b1;
        end
        exp_rem = rem;
    endfunction

    function automatic logic [24:0] exp_vec();
        return {5'(exp_cnt[4]), 5'(exp_cnt[3]), 5'(exp_cnt[2]), 5'(exp_cnt[1]), 5'(exp_cnt[0])};
    endfunction

    function automatic logic [24:0] obs_vec();
        return {bus.dollar_out, bus.half_dollar_out, bus.quarter_out, bus.dime_out, bus.nickel_out};
    endfunction

    function automatic logic [40:0] all_outputs();
        return {bus.eject_req, bus.eject_coin, bus.busy, bus.done, bus.fail, bus.jam,
                bus.remaining, obs_vec()};
    endfunction

    function automatic bit seq_matches();
        if (seen_q.size() != exp_seq.size()) return 1'b0;
        foreach (seen_q[i]) if (seen_q[i] != exp_seq[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Starts a payout and plays the ejector until done/fail or the cycle budget runs out
    task automatic run_payout(input int amt, input logic [4:0] av, input int ack_delay,
                              input bit never_ack, input int restart_at, input int budget);
        int cyc;
        int run_len;
        bit fin;
        bit expired;
        bus.avail = av;
        seen_q.delete();
        got_done = 1'b0;
        got_fail = 1'b0;
        req_cycles = 0;
        expired = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.amount = amt[7:0];
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        run_len = 0;
        fin = 1'b0;
        while (!fin) begin
            bus.eject_ack = 1'b0;
            bus.start = (cyc == restart_at);
            if (cyc == restart_at) bus.amount = 8'd5;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                fin = 1'b1;
            end else if (bus.fail === 1'b1) begin
                got_fail = 1'b1;
                fin = 1'b1;
            end else if (cyc >= budget) begin
                expired = 1'b1;
                fin = 1'b1;
            end else begin
                if (bus.eject_req === 1'b1) begin
                    if (run_len == 0) seen_q.push_back(int'(bus.eject_coin));
                    run_len++;
                    req_cycles++;
                    if (!never_ack && run_len == ack_delay) bus.eject_ack = 1'b1;
                end else begin
                    run_len = 0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        bus.eject_ack = 1'b0;
        n_checks++;
        if (expired) begin
            n_fail++;
            $display("FAIL payout_bound: amount=%0d no done/fail within %0d cycles", amt, budget);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.amount = 8'd0;
        bus.avail = 5'b00000;
        bus.eject_ack = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outputs() !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (all_outputs() !== 41'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected 0", all_outputs());
        end
    endtask

    task automatic test_zero_amount();
        bus.avail = 5'b11111;
        @(negedge clk);
        bus.start = 1'b1;
        bus.amount = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_select: busy,done=%b expected 10", {bus.busy, bus.done});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.eject_req} !== 3'b110) begin
            n_fail++;
            $display("FAIL zero_done: busy,done,req=%b expected 110", {bus.busy, bus.done, bus.eject_req});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_exit: busy,done=%b expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_greedy();
        int amts[4]   = '{10, 39, 3, 40};
        logic [4:0] avs[4] = '{5'b11111, 5'b11111, 5'b00010, 5'b00001};
        int amt;
        logic [4:0] av;
        int dly;
        for (int k = 0; k < 14; k++) begin
            if (k < 4) begin
                amt = amts[k];
                av = avs[k];
                dly = (k == 3) ? 1 : 2;
            end else begin
                amt = $urandom_range(0, 120);
                av = 5'($urandom_range(0, 31));
                dly = $urandom_range(1, 4);
            end
            model(amt, av);
            run_payout(amt, av, dly, 1'b0, -1, 3000);
            n_checks++;
            if ({got_done, got_fail} !== {!exp_fail, exp_fail}) begin
                n_fail++;
                $display("FAIL greedy_outcome[%0d]: done,fail=%b%b expected %b%b (amount=%0d avail=%b)",
                         k, got_done, got_fail, !exp_fail, exp_fail, amt, av);
            end
            n_checks++;
            if (!seq_matches()) begin
                n_fail++;
                $display("FAIL greedy_sequence[%0d]: got %0d coins %p expected %0d coins %p",
                         k, seen_q.size(), seen_q, exp_seq.size(), exp_seq);
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL greedy_counts[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
            n_checks++;
            if (bus.remaining !== 8'(exp_rem)) begin
                n_fail++;
                $display("FAIL greedy_remaining[%0d]: got %0d expected %0d", k, bus.remaining, exp_rem);
            end
            n_checks++;
            if (bus.jam !== 1'b0) begin
                n_fail++;
                $display("FAIL greedy_jam[%0d]: got %b expected 0", k, bus.jam);
            end
        end
    endtask

    task automatic test_timeout();
        run_payout(4, 5'b11111, 1, 1'b1, -1, 200);
        n_checks++;
        if (got_fail !== 1'b1 || req_cycles != ACK_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_req: fail=%b req_cycles=%0d expected fail=1 req_cycles=%0d",
                     got_fail, req_cycles, ACK_TIMEOUT);
        end
        n_checks++;
        if (seen_q.size() != 1 || seen_q[0] != 2) begin
            n_fail++;
            $display("FAIL timeout_coin: got %p expected one dime (2)", seen_q);
        end
        n_checks++;
        if ({bus.jam, bus.remaining, obs_vec()} !== {1'b1, 8'd4, 25'd0}) begin
            n_fail++;
            $display("FAIL timeout_state: jam=%b remaining=%0d counts=%h expected jam=1 remaining=4 counts=0",
                     bus.jam, bus.remaining, obs_vec());
        end
        @(negedge clk);
        n_checks++;
        if ({bus.jam, bus.fail, bus.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_sticky: jam,fail,busy=%b expected 100", {bus.jam, bus.fail, bus.busy});
        end
    endtask

    task automatic test_start_while_busy();
        run_payout(20, 5'b11111, 2, 1'b0, 2, 500);
        n_checks++;
        if (got_done !== 1'b1 || seen_q.size() != 1 || seen_q[0] != 5) begin
            n_fail++;
            $display("FAIL busy_start_seq: done=%b coins=%p expected done=1 coins={5}", got_done, seen_q);
        end
        n_checks++;
        if ({bus.remaining, obs_vec()} !== {8'd0, 5'd1, 20'd0}) begin
            n_fail++;
            $display("FAIL busy_start_state: remaining=%0d counts=%h expected 0 and %h",
                     bus.remaining, obs_vec(), {5'd1, 20'd0});
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.eject_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_start_idle: busy,req=%b expected 00", {bus.busy, bus.eject_req});
        end
    endtask

    task automatic test_reset_mid_eject();
        int k;
        bus.avail = 5'b11111;
        @(negedge clk);
        bus.start = 1'b1;
        bus.amount = 8'd20;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.eject_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (bus.eject_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_reach_eject: eject_req=%b expected 1", bus.eject_req);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outputs() !== 41'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h expected 0", all_outputs());
        end
        @(negedge clk);
        rst = 1'b0;
        model(1, 5'b11111);
        run_payout(1, 5'b11111, 2, 1'b0, -1, 200);
        n_checks++;
        if (got_done !== 1'b1 || !seq_matches() || obs_vec() !== exp_vec() || bus.remaining !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_fresh: done=%b coins=%p counts=%h remaining=%0d expected done=1 coins={1} counts=%h remaining=0",
                     got_done, seen_q, obs_vec(), bus.remaining, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_zero_amount();
        test_greedy();
        test_timeout();
        test_start_while_busy();
        test_reset_mid_eject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
